// File: rtl/fp_alu_pkg.sv
// Shared definitions for the arbitrated single-precision add/subtract unit:
// FSM state encoding, IEEE-754 field constants and small helper functions.
package fp_alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Exponent field value that marks infinity / NaN
  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

  // Width of the requester identifier carried with each operation
  localparam int ID_W = 1;

  // True when the operand is infinity or NaN
  function automatic logic is_special(input logic [31:0] x);
    return (x[30:23] == EXP_ALL_ONES);
  endfunction

  // Leading-zero count of a 27-bit value (27 when the value is zero)
  function automatic logic [4:0] clz27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/Alu_addAndSubtract.sv
// Combinational IEEE-754 single-precision adder/subtractor with
// round-to-nearest-even. Infinity/NaN operands only raise 'exception';
// the numeric result for them is not meaningful.
module Alu_addAndSubtract
  import fp_alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] result,
  output logic        exception
);

  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic        a_big;
  logic        sx, sy;
  logic [7:0]  ex, ey;
  logic [23:0] mx, my;
  logic [7:0]  d;
  logic [53:0] ywide;
  logic [26:0] ya;
  logic        eff_sub;
  logic [27:0] sum;
  logic        zero_sum;
  logic [4:0]  lz;
  logic [9:0]  shift;
  logic [26:0] mn;
  logic [9:0]  en;
  logic        round_up;
  logic [24:0] mr;
  logic [9:0]  ef;
  logic [22:0] frac;
  logic        hidden;

  // Align, add/subtract, normalise and round the two operands
  always_comb begin
    sa = a[31];
    sb = b[31] ^ sub;
    // Denormals/zero use exponent 1 with a clear hidden bit
    ea = (a[30:23] == 8'h00) ? 8'h01 : a[30:23];
    eb = (b[30:23] == 8'h00) ? 8'h01 : b[30:23];
    ma = {(a[30:23] != 8'h00), a[22:0]};
    mb = {(b[30:23] != 8'h00), b[22:0]};

    // X is the operand of larger magnitude; its sign wins
    a_big = ({ea, ma} >= {eb, mb});
    if (a_big) begin
      sx = sa; ex = ea; mx = ma;
      sy = sb; ey = eb; my = mb;
    end else begin
      sx = sb; ex = eb; mx = mb;
      sy = sa; ey = ea; my = ma;
    end

    // Right-align Y keeping guard, round and a sticky bit
    d     = ex - ey;
    ywide = {my, 3'b000, 27'd0} >> d;
    if (d >= 8'd27) begin
      ya = {26'd0, |my};
    end else begin
      ya = {ywide[53:28], ywide[27] | (|ywide[26:0])};
    end

    eff_sub = sx ^ sy;
    if (eff_sub) begin
      sum = {1'b0, mx, 3'b000} - {1'b0, ya};
    end else begin
      sum = {1'b0, mx, 3'b000} + {1'b0, ya};
    end
    zero_sum = (sum == 28'd0);
    lz       = clz27(sum[26:0]);

    // Normalise: carry-out shifts right, otherwise shift left but never
    // below the minimum exponent (gradual underflow)
    if (sum[27]) begin
      shift = 10'd0;
      mn    = {sum[27:2], sum[1] | sum[0]};
      en    = {2'b00, ex} + 10'd1;
    end else begin
      if ({5'd0, lz} < {2'b00, ex}) begin
        shift = {5'd0, lz};
      end else begin
        shift = {2'b00, ex} - 10'd1;
      end
      mn = sum[26:0] << shift;
      en = {2'b00, ex} - shift;
    end

    // Round to nearest, ties to even
    round_up = mn[2] & (mn[1] | mn[0] | mn[3]);
    mr       = {1'b0, mn[26:3]} + {24'd0, round_up};
    if (mr[24]) begin
      ef   = en + 10'd1;
      frac = mr[23:1];
    end else begin
      ef   = en;
      frac = mr[22:0];
    end
    hidden = mr[24] | mr[23];

    if (zero_sum) begin
      // Exact cancellation gives +0; only -0 + -0 stays negative
      result = {(eff_sub ? 1'b0 : sx), 31'd0};
    end else if (ef >= 10'd255) begin
      result = {sx, EXP_ALL_ONES, 23'd0};
    end else if (!hidden) begin
      result = {sx, 8'h00, frac};
    end else begin
      result = {sx, ef[7:0], frac};
    end

    exception = is_special(a) | is_special(b);
  end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Two-requester front end for a shared single-precision add/subtract unit.
// One operation is in flight at a time: IDLE grants a requester and latches
// its operands, EXEC registers the result, RESP holds it until consumed.
module fp_addsub_arbiter
  import fp_alu_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [31:0]     req0_a,
  input  logic [31:0]     req0_b,
  input  logic            req0_sub,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [31:0]     req1_a,
  input  logic [31:0]     req1_b,
  input  logic            req1_sub,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic [31:0]     rsp_result,
  output logic            rsp_exception
);

  state_t          state, state_next;
  logic [ID_W-1:0] ptr;        // requester favoured on contention
  logic            grant_any;
  logic [ID_W-1:0] grant_id;
  logic [31:0]     lat_a, lat_b;
  logic            lat_sub;
  logic [ID_W-1:0] lat_id;
  logic [31:0]     alu_result;
  logic            alu_exc_unused;
  logic            exc_local;

  Alu_addAndSubtract u_alu (
    .a         (lat_a),
    .b         (lat_b),
    .sub       (lat_sub),
    .result    (alu_result),
    .exception (alu_exc_unused)
  );

  // Illegal operands are detected here from the latched operands
  assign exc_local = is_special(lat_a) | is_special(lat_b);

  // Next-state, arbitration and combinational ready generation
  always_comb begin
    state_next = state;
    grant_any  = 1'b0;
    grant_id   = ID_W'(0);
    case (state)
      ST_IDLE: begin
        if (rst) begin
          grant_any = 1'b0;
        end else if (req0_valid && req1_valid) begin
          grant_any = 1'b1;
          grant_id  = (RR_EN != 0) ? ptr : ID_W'(0);
        end else if (req0_valid) begin
          grant_any = 1'b1;
          grant_id  = ID_W'(0);
        end else if (req1_valid) begin
          grant_any = 1'b1;
          grant_id  = ID_W'(1);
        end else begin
          grant_any = 1'b0;
        end
        if (grant_any) begin
          state_next = ST_EXEC;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_RESP;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    req0_ready = grant_any && (grant_id == ID_W'(0));
    req1_ready = grant_any && (grant_id == ID_W'(1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Round-robin pointer moves only when a grant is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= ID_W'(0);
    end else if (grant_any) begin
      ptr <= ~grant_id;
    end else begin
      ptr <= ptr;
    end
  end

  // Capture the granted requester's operation
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_a   <= 32'd0;
      lat_b   <= 32'd0;
      lat_sub <= 1'b0;
      lat_id  <= ID_W'(0);
    end else if (grant_any) begin
      lat_a   <= (grant_id == ID_W'(1)) ? req1_a   : req0_a;
      lat_b   <= (grant_id == ID_W'(1)) ? req1_b   : req0_b;
      lat_sub <= (grant_id == ID_W'(1)) ? req1_sub : req0_sub;
      lat_id  <= grant_id;
    end else begin
      lat_a   <= lat_a;
      lat_b   <= lat_b;
      lat_sub <= lat_sub;
      lat_id  <= lat_id;
    end
  end

  // Response registers: loaded at the end of EXEC, held through RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid     <= 1'b0;
      rsp_id        <= ID_W'(0);
      rsp_result    <= 32'd0;
      rsp_exception <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_valid     <= 1'b1;
      rsp_id        <= lat_id;
      rsp_result    <= exc_local ? 32'd0 : alu_result;
      rsp_exception <= exc_local;
    end else if ((state == ST_RESP) && rsp_ready) begin
      rsp_valid     <= 1'b0;
      rsp_id        <= rsp_id;
      rsp_result    <= rsp_result;
      rsp_exception <= rsp_exception;
    end else begin
      rsp_valid     <= rsp_valid;
      rsp_id        <= rsp_id;
      rsp_result    <= rsp_result;
      rsp_exception <= rsp_exception;
    end
  end

endmodule

// File: doc/fp_addsub_arbiter.md
FP_ADDSUB_ARBITER -- requirements
Module: fp_addsub_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with port 0 highest.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port req0_valid, input, 1 bit: requester 0 presents an operation.
REQ-005 SHALL have port req0_ready, output, 1 bit: requester 0 operation accepted this cycle.
REQ-006 SHALL have ports req0_a and req0_b, input, 32 bits each: IEEE-754 single-precision operands.
REQ-007 SHALL have port req0_sub, input, 1 bit: 1 = a-b, 0 = a+b.
REQ-008 SHALL have ports req1_valid, req1_ready, req1_a, req1_b and req1_sub, identical to the req0 ports, for requester 1.
REQ-009 SHALL have port rsp_valid, output, 1 bit: a result is pending.
REQ-010 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port rsp_id, output, 1 bit: the requester that owns the result.
REQ-012 SHALL have port rsp_result, output, 32 bits: the IEEE-754 result.
REQ-013 SHALL have port rsp_exception, output, 1 bit: an illegal operand was detected.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC and RESP.
REQ-015 IDLE: when any reqN_valid is high, SHALL grant one port, assert only that port's reqN_ready combinationally in the same cycle, latch its a, b, sub and id, then go to EXEC.
REQ-016 reqN_ready SHALL be 0 in every state other than IDLE and for any port that is not granted.
REQ-017 When both requests are valid and RR_EN=1, SHALL grant the port not granted last; the initial pointer after reset SHALL favour port 0.
REQ-018 When RR_EN=0, SHALL always grant port 0 when both requests are valid.
REQ-019 EXEC: latched operands drive the shared add/sub datapath; result and exception SHALL be registered at the end of EXEC, then the FSM goes to RESP.
REQ-020 RESP: rsp_valid SHALL be 1; rsp_id, rsp_result and rsp_exception SHALL be held stable until a cycle with rsp_ready=1, after which the FSM returns to IDLE.
REQ-021 Latency: an operation accepted in cycle N SHALL assert rsp_valid in cycle N+2.
REQ-022 Throughput: at most one accept per 3 cycles; no new accept SHALL occur in the cycle of the rsp handshake.
REQ-023 rsp_exception SHALL equal (latched a[30:23]==8'hFF) | (latched b[30:23]==8'hFF); when it is 1, rsp_result SHALL be 32'h0.
REQ-024 A requester that deasserts valid before being granted SHALL lose nothing; no state change results.
REQ-025 The round-robin pointer SHALL update only on a grant, never on idle cycles.

Reset
REQ-026 On rst=1 at a clock edge: state = IDLE, rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_exception = 0, pointer favours port 0.
REQ-027 rst in EXEC or RESP SHALL discard the in-flight operation with no response produced.
REQ-028 reqN_ready SHALL be 0 while rst=1.

Structure
REQ-029 The shared package fp_alu_pkg SHALL hold the FSM state encoding, the 8'hFF exponent-all-ones constant and the requester-id width.
REQ-030 SHALL instantiate exactly one sub-module, the team's combinational add/subtract unit Alu_addAndSubtract, driven only from the latched operand registers.
REQ-031 Exception detection SHALL be computed locally per REQ-023 and SHALL NOT use the exception output of Alu_addAndSubtract.

Verification
REQ-032 Add: req0 a=0x3F800000, b=0x40000000, sub=0, accepted cycle N -> rsp_valid at N+2, rsp_result=0x40400000, rsp_id=0, rsp_exception=0.
REQ-033 Subtract: req1 a=0x40400000, b=0x3F800000, sub=1 -> rsp_result=0x40000000, rsp_id=1.
REQ-034 Contention: both requests valid continuously with RR_EN=1 and rsp_ready=1 -> grant order 0,1,0,1; with RR_EN=0 -> grant order 0,0,0.
REQ-035 Exception: a=0x7F800000, b=0x3F800000 -> rsp_exception=1, rsp_result=0x00000000.
REQ-036 Backpressure: rsp_ready held 0 for 5 cycles in RESP -> outputs stable, both reqN_ready=0, single handshake when rsp_ready rises.
REQ-037 Reset: rst pulsed in EXEC -> next cycle state IDLE, rsp_valid=0, no response for the dropped operation, next request granted to port 0.
